// File: rtl/coin_acceptor_if.sv
// Signal bundle between the raw coin sensors / vending FSM and the coin acceptor front end.
// The acceptor uses the slave modport; the environment driving sensors uses master.
interface coin_acceptor_if;
   logic       coin5_raw;
   logic       coin10_raw;
   logic       enable;
   logic       clr_total;
   logic [1:0] coin_code;
   logic       reject;
   logic [7:0] total_rs;
   logic       busy;

   modport slave (
      input  coin5_raw,
      input  coin10_raw,
      input  enable,
      input  clr_total,
      output coin_code,
      output reject,
      output total_rs,
      output busy
   );

   modport master (
      output coin5_raw,
      output coin10_raw,
      output enable,
      output clr_total,
      input  coin_code,
      input  reject,
      input  total_rs,
      input  busy
   );
endinterface

// File: rtl/coin_acceptor.sv
// Coin sensor front end: synchronises and debounces the raw sensor lines, then emits one
// coin code (or reject) pulse per physical coin and keeps a saturating inserted-value total.
module coin_acceptor #(
   parameter int DEBOUNCE_CYC = 4,
   parameter int HOLDOFF_CYC  = 8
) (
   input logic            clk,
   input logic            rst,
   coin_acceptor_if.slave bus
);

   localparam int CNT_MAX = (DEBOUNCE_CYC > HOLDOFF_CYC) ? DEBOUNCE_CYC : HOLDOFF_CYC;
   localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;
   localparam logic [CNT_W-1:0] DEB_LAST  = CNT_W'(DEBOUNCE_CYC - 1);
   localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(HOLDOFF_CYC - 1);

   localparam logic [1:0] IDLE     = 2'd0;
   localparam logic [1:0] DEBOUNCE = 2'd1;
   localparam logic [1:0] RELEASE  = 2'd2;
   localparam logic [1:0] HOLDOFF  = 2'd3;

   logic [1:0]       sync1;
   logic [1:0]       s;
   logic [1:0]       samp;
   logic [1:0]       samp_nxt;
   logic [1:0]       state;
   logic [1:0]       state_nxt;
   logic [CNT_W-1:0] cnt;
   logic [CNT_W-1:0] cnt_nxt;
   logic             accept;
   logic             refuse;
   logic [8:0]       coin_val;
   logic [8:0]       sum;
   logic [7:0]       total_nxt;

   // The sampled pair must stay unchanged for the whole debounce window, otherwise it is a glitch.
   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      samp_nxt  = samp;
      accept    = 1'b0;
      refuse    = 1'b0;
      case (state)
         IDLE: begin
            if (s != 2'b00) begin
               state_nxt = DEBOUNCE;
               samp_nxt  = s;
               cnt_nxt   = '0;
            end
         end
         DEBOUNCE: begin
            if (s != samp) begin
               state_nxt = IDLE;
            end else if (cnt == DEB_LAST) begin
               state_nxt = RELEASE;
               cnt_nxt   = '0;
               if (samp == 2'b11 || !bus.enable) refuse = 1'b1;
               else                              accept = 1'b1;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         RELEASE: begin
            if (s == 2'b00) begin
               if (cnt == DEB_LAST) begin
                  state_nxt = HOLDOFF;
                  cnt_nxt   = '0;
               end else begin
                  cnt_nxt = cnt + 1'b1;
               end
            end else begin
               cnt_nxt = '0;
            end
         end
         HOLDOFF: begin
            if (cnt == HOLD_LAST) begin
               state_nxt = IDLE;
               cnt_nxt   = '0;
            end else begin
               cnt_nxt = cnt + 1'b1;
            end
         end
         default: begin
            state_nxt = IDLE;
            cnt_nxt   = '0;
         end
      endcase
   end

   // A clear coinciding with an accept wipes the old total before the new coin is added.
   always_comb begin
      coin_val  = (samp == 2'b01) ? 9'd5 : 9'd10;
      sum       = (bus.clr_total ? 9'd0 : {1'b0, bus.total_rs}) + (accept ? coin_val : 9'd0);
      total_nxt = (sum > 9'd255) ? 8'd255 : sum[7:0];
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         sync1         <= 2'b00;
         s             <= 2'b00;
         samp          <= 2'b00;
         state         <= IDLE;
         cnt           <= '0;
         bus.coin_code <= 2'b00;
         bus.reject    <= 1'b0;
         bus.total_rs  <= 8'd0;
         bus.busy      <= 1'b0;
      end else begin
         sync1         <= {bus.coin10_raw, bus.coin5_raw};
         s             <= sync1;
         samp          <= samp_nxt;
         state         <= state_nxt;
         cnt           <= cnt_nxt;
         bus.coin_code <= accept ? samp : 2'b00;
         bus.reject    <= refuse;
         bus.total_rs  <= total_nxt;
         bus.busy      <= (state_nxt != IDLE);
      end
   end

endmodule

// File: tb/tb_coin_acceptor.sv
// Directed bench for coin_acceptor: hand-computed pulse timing, totals, rejects and reset cases
// with the default DEBOUNCE_CYC=4 / HOLDOFF_CYC=8.
module tb_coin_acceptor;

   logic clk = 1'b0;
   logic rst;
   int   total_checks = 0;
   int   bad_checks   = 0;
   int   n5;
   int   n10;
   int   nrej;
   int   first_at;
   logic timed_out;

   coin_acceptor_if bus ();

   coin_acceptor dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic tick(input int n);
      repeat (n) begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic check_output(input string tag, input logic [8:0] observed, input logic [8:0] expected);
      total_checks++;
      assert (observed === expected) else begin
         bad_checks++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   // Raw lines high for edges k..k+hold-1, then low; tallies pulses until the DUT is idle again.
   task automatic apply_stimulus(input logic [1:0] lines, input int hold);
      n5        = 0;
      n10       = 0;
      nrej      = 0;
      first_at  = -1;
      bus.coin10_raw = lines[1];
      bus.coin5_raw  = lines[0];
      tick(1);
      for (int i = 1; i < hold + 80; i++) begin
         if (i == hold) begin
            bus.coin10_raw = 1'b0;
            bus.coin5_raw  = 1'b0;
         end
         tick(1);
         if (bus.coin_code == 2'b01) n5++;
         if (bus.coin_code == 2'b10) n10++;
         if (bus.reject) nrej++;
         if ((bus.coin_code != 2'b00 || bus.reject) && first_at < 0) first_at = i;
         if (i >= hold && !bus.busy) break;
      end
      timed_out = bus.busy;
   endtask

   initial begin
      rst            = 1'b1;
      bus.coin5_raw  = 1'b0;
      bus.coin10_raw = 1'b0;
      bus.enable     = 1'b1;
      bus.clr_total  = 1'b0;
      tick(2);
      check_output("reset_code", 9'(bus.coin_code), 9'd0);
      check_output("reset_reject", 9'(bus.reject), 9'd0);
      check_output("reset_total", 9'(bus.total_rs), 9'd0);
      check_output("reset_busy", 9'(bus.busy), 9'd0);
      rst = 1'b0;

      $display("[TB] single 5 Rs coin, exact timing");
      bus.coin5_raw = 1'b1;
      tick(1);
      for (int j = 1; j <= 6; j++) begin
         tick(1);
         check_output($sformatf("t1_code_k%0d", j), 9'(bus.coin_code), (j == 6) ? 9'd1 : 9'd0);
      end
      check_output("t1_busy", 9'(bus.busy), 9'd1);
      check_output("t1_reject", 9'(bus.reject), 9'd0);
      tick(1);
      check_output("t1_code_k7", 9'(bus.coin_code), 9'd0);
      check_output("t1_total", 9'(bus.total_rs), 9'd5);
      tick(2);
      bus.coin5_raw = 1'b0;
      tick(13);
      check_output("t1_busy_k22", 9'(bus.busy), 9'd1);
      tick(1);
      check_output("t1_busy_k23", 9'(bus.busy), 9'd0);

      $display("[TB] 10 Rs then 5 Rs");
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      apply_stimulus(2'b10, 10);
      check_output("t2_n10", 9'(n10), 9'd1);
      check_output("t2_n5", 9'(n5), 9'd0);
      check_output("t2_at", 9'(first_at), 9'd6);
      check_output("t2_timeout", 9'(timed_out), 9'd0);
      check_output("t2_total_a", 9'(bus.total_rs), 9'd10);
      tick(1);
      check_output("t2_gap_busy", 9'(bus.busy), 9'd0);
      apply_stimulus(2'b01, 10);
      check_output("t2_second_n5", 9'(n5), 9'd1);
      check_output("t2_second_n10", 9'(n10), 9'd0);
      check_output("t2_total_b", 9'(bus.total_rs), 9'd15);

      $display("[TB] short glitch");
      apply_stimulus(2'b01, 3);
      check_output("t3_n5", 9'(n5), 9'd0);
      check_output("t3_rej", 9'(nrej), 9'd0);
      check_output("t3_timeout", 9'(timed_out), 9'd0);
      check_output("t3_total", 9'(bus.total_rs), 9'd15);

      $display("[TB] double sensor hit");
      apply_stimulus(2'b11, 10);
      check_output("t4_rej", 9'(nrej), 9'd1);
      check_output("t4_codes", 9'(n5 + n10), 9'd0);
      check_output("t4_at", 9'(first_at), 9'd6);
      check_output("t4_total", 9'(bus.total_rs), 9'd15);

      $display("[TB] coin while disabled");
      bus.enable = 1'b0;
      apply_stimulus(2'b10, 10);
      bus.enable = 1'b1;
      check_output("t4b_rej", 9'(nrej), 9'd1);
      check_output("t4b_n10", 9'(n10), 9'd0);
      check_output("t4b_total", 9'(bus.total_rs), 9'd15);

      $display("[TB] saturation and clear");
      rst = 1'b1;
      tick(1);
      rst = 1'b0;
      for (int c = 0; c < 25; c++) apply_stimulus(2'b10, 10);
      check_output("t5_total_250", 9'(bus.total_rs), 9'd250);
      apply_stimulus(2'b10, 10);
      check_output("t5_n10", 9'(n10), 9'd1);
      check_output("t5_total_sat", 9'(bus.total_rs), 9'd255);
      apply_stimulus(2'b01, 10);
      check_output("t5_total_hold", 9'(bus.total_rs), 9'd255);
      bus.coin5_raw = 1'b1;
      tick(6);
      bus.clr_total = 1'b1;
      tick(1);
      bus.clr_total = 1'b0;
      check_output("t5_clr_code", 9'(bus.coin_code), 9'd1);
      check_output("t5_clr_total", 9'(bus.total_rs), 9'd5);
      bus.coin5_raw = 1'b0;
      for (int i = 0; i < 40 && bus.busy; i++) tick(1);
      check_output("t5_idle", 9'(bus.busy), 9'd0);
      bus.clr_total = 1'b1;
      tick(1);
      bus.clr_total = 1'b0;
      check_output("t5_clr_alone", 9'(bus.total_rs), 9'd0);

      $display("[TB] reset mid-operation");
      bus.coin5_raw = 1'b1;
      tick(4);
      check_output("t6_busy_pre", 9'(bus.busy), 9'd1);
      rst = 1'b1;
      tick(1);
      check_output("t6_deb_code", 9'(bus.coin_code), 9'd0);
      check_output("t6_deb_busy", 9'(bus.busy), 9'd0);
      check_output("t6_deb_total", 9'(bus.total_rs), 9'd0);
      rst = 1'b0;
      n5 = 0;
      first_at = -1;
      for (int i = 1; i <= 10; i++) begin
         tick(1);
         if (bus.coin_code == 2'b01) begin
            n5++;
            if (first_at < 0) first_at = i;
         end
      end
      check_output("t6_fresh_n5", 9'(n5), 9'd1);
      check_output("t6_fresh_at", 9'(first_at), 9'd7);
      check_output("t6_fresh_total", 9'(bus.total_rs), 9'd5);
      rst = 1'b1;
      tick(1);
      check_output("t6_rel_code", 9'(bus.coin_code), 9'd0);
      check_output("t6_rel_reject", 9'(bus.reject), 9'd0);
      check_output("t6_rel_busy", 9'(bus.busy), 9'd0);
      check_output("t6_rel_total", 9'(bus.total_rs), 9'd0);
      bus.coin5_raw = 1'b0;
      tick(1);
      rst = 1'b0;
      n5 = 0;
      for (int i = 0; i < 12; i++) begin
         tick(1);
         if (bus.coin_code != 2'b00 || bus.reject) n5++;
      end
      check_output("t6_no_pulse", 9'(n5), 9'd0);
      check_output("t6_final_busy", 9'(bus.busy), 9'd0);

      $display("test done: total=%0d bad=%0d", total_checks, bad_checks);
      $finish;
   end

endmodule
